security_code_controller: RTL



---
 rtl/security_code_controller_if.sv | 23 ++
 rtl/security_code_controller.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/security_code_controller_if.sv
// Keypad-in / lock-out signal bundle for the two-digit security code controller.
// master = keypad/environment side, slave = controller side.
interface security_code_controller_if;
    logic       key_any;
    logic [1:0] key_code;
    logic       unlock;
    logic       alarm;
    logic       error;
    logic [1:0] disp_digit;
    logic       disp_pos;
    logic [2:0] fail_count;
    logic [2:0] state;

    modport master (
        output key_any, key_code,
        input  unlock, alarm, error, disp_digit, disp_pos, fail_count, state
    );

    modport slave (
        input  key_any, key_code,
        output unlock, alarm, error, disp_digit, disp_pos, fail_count, state
    );
endinterface

// File: rtl/security_code_controller.sv
// Two-digit keypad lock sequencer: captures two presses, checks them against the
// secret code, and drives unlock, error pulse, failure count and alarm lockout.
module security_code_controller #(
    parameter int FIRST_DIGIT    = 2,
    parameter int SECOND_DIGIT   = 3,
    parameter int ENTRY_TIMEOUT  = 16,
    parameter int OPEN_CYCLES    = 8,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 32
) (
    input logic                      CLK,
    input logic                      RST_N,
    security_code_controller_if.slave bus
);
    localparam int TMAX0 = (ENTRY_TIMEOUT > OPEN_CYCLES) ? ENTRY_TIMEOUT : OPEN_CYCLES;
    localparam int TMAX  = (TMAX0 > LOCKOUT_CYCLES) ? TMAX0 : LOCKOUT_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic          key_any_q;
    logic [1:0]    d1_q, d1_d, d2_q, d2_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          unlock_q, unlock_d;
    logic          alarm_q, alarm_d;
    logic          error_q, error_d;
    logic [1:0]    disp_digit_q, disp_digit_d;
    logic          disp_pos_q, disp_pos_d;
    logic [2:0]    fail_count_q, fail_count_d;
    logic          press;

    // Rising edge of key_any only: a key held across a state change never re-triggers.
    assign press = bus.key_any & ~key_any_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            key_any_q    <= 1'b0;
            d1_q         <= '0;
            d2_q         <= '0;
            timer_q      <= '0;
            unlock_q     <= 1'b0;
            alarm_q      <= 1'b0;
            error_q      <= 1'b0;
            disp_digit_q <= '0;
            disp_pos_q   <= 1'b0;
            fail_count_q <= '0;
        end else begin
            state_q      <= state_d;
            key_any_q    <= bus.key_any;
            d1_q         <= d1_d;
            d2_q         <= d2_d;
            timer_q      <= timer_d;
            unlock_q     <= unlock_d;
            alarm_q      <= alarm_d;
            error_q      <= error_d;
            disp_digit_q <= disp_digit_d;
            disp_pos_q   <= disp_pos_d;
            fail_count_q <= fail_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        d1_d         = d1_q;
        d2_d         = d2_q;
        timer_d      = timer_q;
        unlock_d     = unlock_q;
        alarm_d      = alarm_q;
        error_d      = 1'b0;
        disp_digit_d = disp_digit_q;
        disp_pos_d   = disp_pos_q;
        fail_count_d = fail_count_q;
        case (state_q)
            IDLE: begin
                if (press) begin
                    d1_d         = bus.key_code;
                    disp_digit_d = bus.key_code;
                    disp_pos_d   = 1'b0;
                    timer_d      = '0;
                    state_d      = ENTRY;
                end
            end
            ENTRY: begin
                // A press on the final timeout cycle still counts.
                if (press) begin
                    d2_d         = bus.key_code;
                    disp_digit_d = bus.key_code;
                    disp_pos_d   = 1'b1;
                    state_d      = CHECK;
                end else if (timer_q == TW'(ENTRY_TIMEOUT - 1)) begin
                    disp_digit_d = '0;
                    disp_pos_d   = 1'b0;
                    state_d      = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CHECK: begin
                if (d1_q == 2'(FIRST_DIGIT) && d2_q == 2'(SECOND_DIGIT)) begin
                    fail_count_d = '0;
                    unlock_d     = 1'b1;
                    timer_d      = '0;
                    state_d      = OPEN;
                end else if (fail_count_q + 3'd1 == 3'(MAX_FAILS)) begin
                    fail_count_d = 3'(MAX_FAILS);
                    alarm_d      = 1'b1;
                    error_d      = 1'b1;
                    timer_d      = '0;
                    state_d      = LOCKOUT;
                end else begin
                    fail_count_d = fail_count_q + 3'd1;
                    error_d      = 1'b1;
                    state_d      = IDLE;
                end
            end
            OPEN: begin
                if (timer_q == TW'(OPEN_CYCLES - 1)) begin
                    unlock_d     = 1'b0;
                    disp_digit_d = '0;
                    disp_pos_d   = 1'b0;
                    state_d      = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            LOCKOUT: begin
                if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
                    alarm_d      = 1'b0;
                    fail_count_d = '0;
                    disp_digit_d = '0;
                    disp_pos_d   = 1'b0;
                    state_d      = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.unlock     = unlock_q;
    assign bus.alarm      = alarm_q;
    assign bus.error      = error_q;
    assign bus.disp_digit = disp_digit_q;
    assign bus.disp_pos   = disp_pos_q;
    assign bus.fail_count = fail_count_q;
    assign bus.state      = state_q;
endmodule
